// File: rtl/gcd_requester.sv
// gcd_requester: start/done initiator for a gcd core, with done watchdog and op counter.
// Define GCD_REQ_CHECK_EN to add a plausibility check of the core result on res_err.
module gcd_requester #(
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             done,
  input  logic [WIDTH-1:0] outp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_timeout,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [15:0] timer;
  logic expired;
  assign expired = timer == 16'(TIMEOUT - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && in_valid) ? ISSUE :
                (state == ISSUE) ? WAIT :
                (state == WAIT && (done || expired)) ? RESP :
                (state == RESP && res_ready) ? IDLE : state;
  end
  // handshake outputs are flops loaded from the next state so they never glitch
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      start       <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
      a           <= '0;
      b           <= '0;
      res_a       <= '0;
      res_b       <= '0;
      res_gcd     <= '0;
      res_timeout <= 1'b0;
      op_count    <= '0;
      timer       <= '0;
    end else begin
      start     <= state_nxt == ISSUE;
      res_valid <= state_nxt == RESP;
      busy      <= state_nxt != IDLE;
      in_ready  <= state_nxt == IDLE;
      if (state == IDLE && in_valid) begin
        a     <= in_a;
        b     <= in_b;
        res_a <= in_a;
        res_b <= in_b;
      end
      if (state == ISSUE) timer <= '0;
      else if (state == WAIT && !done) timer <= timer + 16'd1;
      if (state == WAIT && done) begin
        res_gcd     <= outp;
        res_timeout <= 1'b0;
      end else if (state == WAIT && expired) begin
        res_gcd     <= '0;
        res_timeout <= 1'b1;
      end
      if (state == RESP && res_ready) op_count <= op_count + 1'b1;
    end
`ifdef GCD_REQ_CHECK_EN
  logic [WIDTH-1:0] min_ab;
  logic mismatch;
  assign min_ab = (a < b) ? a : b;
  assign mismatch = (a == '0 || b == '0) ? (outp != '0) : (outp == '0 || outp > min_ab);
  always_ff @(posedge clock or posedge reset)
    if (reset) res_err <= 1'b0;
    else if (state == WAIT && done) res_err <= mismatch;
    else if (state == WAIT && expired) res_err <= 1'b0;
`else
  assign res_err = 1'b0;
`endif
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: transaction-level model of the requester with a built-in core model;
// every output is compared each cycle against the expected values the driver maintains.
module tb_gcd_requester;
  localparam int W = 8, TO = 16, CW = 16;
  logic clock = 0, reset = 1, in_valid = 0, done = 0, res_ready = 0;
  logic [W-1:0] in_a = 0, in_b = 0, outp = 0;
  logic in_ready, start, res_valid, res_timeout, res_err, busy;
  logic [W-1:0] a, b, res_a, res_b, res_gcd;
  logic [CW-1:0] op_count;

  gcd_requester #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start(start), .a(a), .b(b), .done(done), .outp(outp),
    .res_valid(res_valid), .res_ready(res_ready), .res_a(res_a), .res_b(res_b),
    .res_gcd(res_gcd), .res_timeout(res_timeout), .res_err(res_err), .busy(busy),
    .op_count(op_count)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  logic [W-1:0] exp_a = 0, exp_b = 0, exp_ra = 0, exp_rb = 0, exp_g = 0;
  logic exp_to = 0, exp_err = 0, exp_start = 0, exp_busy = 0, exp_rv = 0;
  logic [CW-1:0] exp_cnt = 0;
  logic [W-1:0] seen_g = 0;
  logic seen_to = 0, seen_err = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    if (x == 0 || y == 0) return 0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic implausible(input int x, input int y, input int o);
    if (x == 0 || y == 0) return o != 0;
    return o == 0 || o > ((x < y) ? x : y);
  endfunction

  task automatic cmp_all();
    chk("start", start, exp_start);
    chk("busy", busy, exp_busy);
    chk("in_ready", in_ready, !exp_busy);
    chk("res_valid", res_valid, exp_rv);
    chk("a", a, exp_a);
    chk("b", b, exp_b);
    chk("res_a", res_a, exp_ra);
    chk("res_b", res_b, exp_rb);
    chk("res_gcd", res_gcd, exp_g);
    chk("res_timeout", res_timeout, exp_to);
    chk("res_err", res_err, exp_err);
    chk("op_count", op_count, exp_cnt);
  endtask

  initial forever begin
    @(negedge clock);
    #1 cmp_all();
  end

  // One full transaction: dly = WAIT cycle whose closing edge carries done (0 = never),
  // bp = backpressure cycles in RESP, late = RESP cycle with a stray done (-1 = none),
  // nv/na/nb = next pair presented on in_* during RESP.
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int dly,
                    input logic use_ov, input logic [W-1:0] ov, input int bp, input int late,
                    input logic nv, input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W-1:0] r;
    in_valid = 1; in_a = ia; in_b = ib;
    @(negedge clock);
    in_valid = 0;
    exp_a = ia; exp_b = ib; exp_ra = ia; exp_rb = ib; exp_start = 1; exp_busy = 1;
    @(negedge clock);
    exp_start = 0;
    r = use_ov ? ov : gcd_ref(ia, ib);
    for (int i = 1; i <= TO; i++) begin
      if (i == dly) begin done = 1; outp = r; end
      @(negedge clock);
      done = 0;
      if (i == dly) begin
        exp_g = r; exp_to = 0;
`ifdef GCD_REQ_CHECK_EN
        exp_err = implausible(ia, ib, r);
`else
        exp_err = 0;
`endif
        break;
      end
      if (i == TO) begin exp_g = 0; exp_to = 1; exp_err = 0; end
    end
    exp_rv = 1;
    seen_g = res_gcd; seen_to = res_timeout; seen_err = res_err;
    if (nv) begin in_valid = 1; in_a = na; in_b = nb; end
    for (int j = 0; j < bp; j++) begin
      if (j == late) begin done = 1; outp = W'($urandom); end
      @(negedge clock);
      done = 0;
    end
    res_ready = 1;
    @(negedge clock);
    res_ready = 0;
    exp_rv = 0; exp_busy = 0; exp_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    chk("ref_48_18", gcd_ref(48, 18), 6);
    chk("ref_0_9", gcd_ref(0, 9), 0);
    chk("ref_17_5", gcd_ref(17, 5), 1);
    repeat (2) @(negedge clock);
    reset = 0;
    @(negedge clock);
    op(48, 18, 10, 0, 0, 0, -1, 0, 0, 0);
    chk("t1_gcd", seen_g, 6);
    chk("t1_to", seen_to, 0);
    chk("t1_cnt", op_count, 1);
    op(35, 21, 4, 0, 0, 5, -1, 1, 20, 8);
    op(20, 8, 3, 0, 0, 0, -1, 0, 0, 0);
    chk("t2_cnt", op_count, 3);
    op(9, 6, 0, 0, 0, 6, 3, 0, 0, 0);
    chk("t3_gcd", seen_g, 0);
    chk("t3_to", seen_to, 1);
    op(25, 15, 16, 0, 0, 0, -1, 0, 0, 0);
    chk("t4_gcd", seen_g, 5);
    chk("t4_to", seen_to, 0);
    done = 1; outp = 33;
    @(negedge clock);
    done = 0;
    @(negedge clock);
    op(12, 8, 3, 1, 7, 0, -1, 0, 0, 0);
`ifdef GCD_REQ_CHECK_EN
    chk("t6_err_7", seen_err, 1);
`else
    chk("t6_err_7", seen_err, 0);
`endif
    op(12, 8, 3, 1, 4, 0, -1, 0, 0, 0);
    chk("t6_err_4", seen_err, 0);
    op(0, 9, 2, 1, 0, 0, -1, 0, 0, 0);
    chk("t6_err_0", seen_err, 0);
    in_valid = 1; in_a = 100; in_b = 75;
    @(negedge clock);
    in_valid = 0;
    exp_a = 100; exp_b = 75; exp_ra = 100; exp_rb = 75; exp_start = 1; exp_busy = 1;
    @(negedge clock);
    exp_start = 0;
    repeat (3) @(negedge clock);
    #2 reset = 1;
    exp_a = 0; exp_b = 0; exp_ra = 0; exp_rb = 0; exp_g = 0; exp_to = 0; exp_err = 0;
    exp_busy = 0; exp_rv = 0; exp_cnt = 0;
    #1 cmp_all();
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    done = 1; outp = 25;
    @(negedge clock);
    done = 0;
    repeat (2) @(negedge clock);
    chk("t5_cnt", op_count, 0);
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
      op(ra, rb, $urandom_range(1, 20), $urandom_range(0, 3) == 0, W'($urandom),
         $urandom_range(0, 3), -1, 0, 0, 0);
    end
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
Initiator-side controller for the gcd start/done compute protocol. Takes operand pairs from an upstream valid/ready stream and issues each to a gcd core as a one-cycle start pulse. It holds a/b stable until the core's done pulse, then returns the result with its operands on a downstream valid/ready stream. Adds a done-timeout watchdog and a completed-operation counter. One request outstanding at a time.

Parameters:
WIDTH, 8, operand/result width; must match the attached core.
TIMEOUT, 1023, WAIT cycles without done before a timeout result is produced; legal range 1..2^16-1.
CNT_W, 16, width of op_count.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream operand pair valid
in_ready  output  1  requester can accept a pair
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
start  output  1  one-cycle request pulse to core
a  output  WIDTH  operand a to core; registered
b  output  WIDTH  operand b to core; registered
done  input  1  core completion pulse
outp  input  WIDTH  core result; valid in the done cycle
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_a  output  WIDTH  operand a of this result
res_b  output  WIDTH  operand b of this result
res_gcd  output  WIDTH  result; 0 on timeout
res_timeout  output  1  result produced by the watchdog, not the core
res_err  output  1  plausibility check failed; see Optional Feature
busy  output  1  state != IDLE
op_count  output  CNT_W  results consumed downstream; wraps modulo 2^CNT_W

Behaviour:
- Reset (async): state=IDLE. start, res_valid, res_timeout, res_err, busy = 0. a, b, res_a, res_b, res_gcd, op_count, timer = 0.
- All outputs are registered. in_ready = (state==IDLE), decoded from state.
- IDLE: in_ready=1. At an edge with in_valid=1, capture in_a/in_b into a/b and res_a/res_b, then go to ISSUE.
- ISSUE: lasts exactly 1 cycle. start=1 only in this cycle; timer cleared. Go to WAIT.
- WAIT: start=0; a/b held stable.
  - done=1 at an edge: res_gcd<=outp, res_timeout<=0, go to RESP.
  - Otherwise timer++. If the edge ends the TIMEOUT-th WAIT cycle: res_gcd<=0, res_timeout<=1, go to RESP.
  - done and timeout at the same edge: done wins.
- RESP: res_valid=1. res_* held stable while res_ready=0. At an edge with res_ready=1, op_count++ and go to IDLE. No in_* pair is accepted in the same edge.
- done outside WAIT is ignored: no state change, no result update. This includes a late done after a timeout.
- Core protocol: the core samples a/b on start. It returns 0 when either operand is 0.
- Throughput: at most one pair per 4 cycles (IDLE, ISSUE, ≥1 WAIT, RESP).
- Latency: start is high in the cycle after accept. res_valid rises on the edge where done is sampled.
- Reset mid-operation aborts immediately; the core is not notified. A done arriving after reset release is ignored because state=IDLE.

Optional Feature:
Macro GCD_REQ_CHECK_EN.
- Defined: on a done-capture, res_err <= mismatch, where mismatch is:
  - either operand 0 and outp != 0; or
  - both operands nonzero and (outp == 0 or outp > min(a,b)).
- res_err is held with the result and cleared on timeout and on reset.
- Not defined: res_err is constant 0 and no comparator logic is generated.
- The port exists in both builds.

Test Plan:
1. in_a=48, in_b=18; core model gives done with outp=6 after 10 cycles; res_ready=1 -> start is one cycle, exactly one cycle after accept; a/b=48/18 held through WAIT; res_valid with res_gcd=6, res_a=48, res_b=18, res_timeout=0; op_count 0->1.
2. Backpressure: res_ready low for 5 cycles after res_valid; in_valid held high with a second pair -> res_* stable, in_ready=0, second pair accepted only after the res_ready handshake; op_count=2 at end.
3. TIMEOUT=16, core never asserts done -> res_valid rises on the edge ending the 16th WAIT cycle; res_gcd=0, res_timeout=1. A done injected 3 cycles later is ignored.
4. TIMEOUT=16, done with outp=5 on the edge ending the 16th WAIT cycle -> res_gcd=5, res_timeout=0.
5. Reset asserted in WAIT cycle 4 -> all outputs at reset values immediately. Post-release done ignored; op_count=0; in_ready=1.
6. GCD_REQ_CHECK_EN defined: a=12, b=8, outp=7 -> res_err=1; outp=4 -> res_err=0; a=0, b=9, outp=0 -> res_err=0. Macro undefined with outp=7 -> res_err=0.
